// File: rtl/dmem_io_responder.sv
// dmem_io_responder: CPU data-bus responder serving a data RAM and a switch/LED/timer I/O page
module dmem_io_responder #(
  parameter int RAM_DEPTH = 240,
  parameter int PRESCALE = 1000,
  parameter logic [7:0] IO_BASE = 8'hF0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN_L,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       MW,
  output logic [7:0] RDATA,
  input  logic [7:0] SW_IN,
  output logic [7:0] LED_OUT,
  output logic       TIRQ
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [7:0] mem [RAM_DEPTH];
  logic [7:0] sw_s1, sw_s2, led, tcnt, tcmp, off;
  logic [PW-1:0] presc;
  logic t_en, flag, we, ram_hit, io_hit, tick, match, wr_led, wr_tctl, wr_tcmp;
  assign we = MW && !EN_L;
  assign off = ADDR - IO_BASE;
  assign ram_hit = int'(ADDR) < RAM_DEPTH;
  assign io_hit = ADDR >= IO_BASE && off < 8'd8;
  assign wr_led = we && io_hit && off == 8'd1;
  assign wr_tctl = we && io_hit && off == 8'd3;
  assign wr_tcmp = we && io_hit && off == 8'd4;
  assign tick = t_en && presc == PW'(PRESCALE - 1);
  assign match = tcnt == tcmp;
  assign LED_OUT = led;
  assign TIRQ = flag;
  // Data RAM: never reset, written only for in-range addresses so nothing aliases
  always_ff @(posedge CLK)
    if (we && ram_hit) mem[ADDR] <= WDATA;
  // Switch synchronizer, LED, and interval timer; a same-cycle match tick beats the W1C clear
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      led <= '0;
      tcnt <= '0;
      tcmp <= 8'hFF;
      t_en <= 1'b0;
      flag <= 1'b0;
      presc <= '0;
    end else begin
      sw_s1 <= SW_IN;
      sw_s2 <= sw_s1;
      if (wr_led) led <= WDATA;
      if (wr_tcmp) tcmp <= WDATA;
      if (wr_tctl) t_en <= WDATA[0];
      flag <= (tick && match) || (flag && !(wr_tctl && WDATA[1]));
      if (tick) tcnt <= match ? 8'd0 : tcnt + 8'd1;
      presc <= (wr_tctl && WDATA[0] && !t_en) || tick ? '0 : t_en ? presc + 1'b1 : presc;
    end
  // Zero-wait-state read mux; unmapped addresses read as zero
  always_comb begin
    RDATA = 8'h00;
    if (ram_hit) RDATA = mem[ADDR];
    else if (io_hit)
      case (off[2:0])
        3'd0: RDATA = sw_s2;
        3'd1: RDATA = led;
        3'd2: RDATA = tcnt;
        3'd3: RDATA = {6'b0, flag, t_en};
        3'd4: RDATA = tcmp;
        default: RDATA = 8'h00;
      endcase
  end
endmodule
